// File: rtl/dataframe_fifo_pkg.sv
// Shared types and constants for the pixel-buffer frame FIFO.
// Write-request classification lives here so policy decisions read as one named action.
package dataframe_fifo_pkg;

  localparam int DATAFRAME_W    = 448;
  localparam int DEFAULT_ADDR_W = 7;
  localparam int DROP_CNT_W     = 16;

  typedef logic [DATAFRAME_W-1:0] frame_t;

  // What happens to a write request on this edge.
  typedef enum logic [1:0] {
    WR_NONE,       // no write requested
    WR_STORE,      // normal store (not full, or paired with an accepted read)
    WR_OVERWRITE,  // full, no read: store and evict the oldest frame
    WR_DISCARD     // full, no read: incoming frame is dropped
  } wr_action_t;

  function automatic wr_action_t classify_write(input logic wr_en,
                                                input logic full,
                                                input logic rd_accept,
                                                input bit   drop_oldest);
    if (!wr_en)                 return WR_NONE;
    else if (!full || rd_accept) return WR_STORE;
    else if (drop_oldest)        return WR_OVERWRITE;
    else                         return WR_DISCARD;
  endfunction

endpackage

// File: rtl/dataframe_fifo_if.sv
// Frame FIFO bus: assembler-side write, drain-side read, and status/error outputs.
// master = the logic driving requests; slave = the FIFO itself.
interface dataframe_fifo_if
  import dataframe_fifo_pkg::*;
#(
  parameter int DATA_W = DATAFRAME_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);
  logic                  wr_en;
  logic [DATA_W-1:0]     data_in;
  logic                  rd_en;
  logic [DATA_W-1:0]     data_out;
  logic                  rd_valid;
  logic [ADDR_W:0]       num_elem;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  err_overwr;
  logic                  err_underrun;
  logic [DROP_CNT_W-1:0] drop_count;
  logic [ADDR_W:0]       high_water;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, num_elem, empty, full, almost_full,
           err_overwr, err_underrun, drop_count, high_water
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, num_elem, empty, full, almost_full,
           err_overwr, err_underrun, drop_count, high_water
  );
endinterface

// File: rtl/dataframe_fifo_mem.sv
// Simple dual-port frame RAM, one write and one registered read port, read-first.
// Only the read register is reset; the array itself maps onto block RAM.
module dataframe_fifo_mem #(
  parameter int DATA_W = 448,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array gets no reset so synthesis can infer block RAM; stale
  // contents are harmless because the pointers gate what is reachable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address write on this edge is not yet visible here: read-first.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dataframe_fifo.sv
// Parametrised frame FIFO: pointers, registered flags, full-policy and error pulses.
// Optional statistics (drop_count, high_water) are built when DATAFRAME_FIFO_STATS_EN is defined.
module dataframe_fifo
  import dataframe_fifo_pkg::*;
#(
  parameter int DATA_W      = DATAFRAME_W,
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int AFULL_LVL   = (2**ADDR_W) - 4,
  parameter bit DROP_OLDEST = 1'b1
) (
  input logic             clk,
  input logic             rstb,
  dataframe_fifo_if.slave bus
);

  localparam int              DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);

  logic [ADDR_W-1:0] wr_head, rd_head;
  logic [ADDR_W:0]   count, count_next;
  logic              empty_q, full_q, afull_q;
  logic              rd_valid_q, err_overwr_q, err_underrun_q;

  logic       rd_accept, wr_commit, rd_advance, overwr_event;
  wr_action_t wr_action;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    rd_accept    = bus.rd_en && !empty_q;
    wr_action    = classify_write(bus.wr_en, full_q, rd_accept, DROP_OLDEST);
    wr_commit    = (wr_action == WR_STORE) || (wr_action == WR_OVERWRITE);
    rd_advance   = rd_accept || (wr_action == WR_OVERWRITE);
    overwr_event = (wr_action == WR_OVERWRITE) || (wr_action == WR_DISCARD);

    // An overwrite evicts one and stores one, so occupancy only moves on
    // an unpaired store or an unpaired read.
    count_next = count;
    if (wr_action == WR_STORE && !rd_accept)  count_next = count + 1'b1;
    else if (rd_accept && !wr_commit)         count_next = count - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_head        <= '0;
      rd_head        <= '0;
      count          <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      afull_q        <= 1'b0;
      rd_valid_q     <= 1'b0;
      err_overwr_q   <= 1'b0;
      err_underrun_q <= 1'b0;
    end else begin
      if (wr_commit)  wr_head <= wr_head + 1'b1;
      if (rd_advance) rd_head <= rd_head + 1'b1;
      count          <= count_next;
      empty_q        <= (count_next == '0);
      full_q         <= (count_next == DEPTH_CNT);
      afull_q        <= (count_next >= AFULL_CNT);
      rd_valid_q     <= rd_accept;
      err_overwr_q   <= overwr_event;
      err_underrun_q <= bus.rd_en && empty_q;
    end
  end

  dataframe_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rstb  (rstb),
    .we    (wr_commit),
    .waddr (wr_head),
    .wdata (bus.data_in),
    .re    (rd_accept),
    .raddr (rd_head),
    .rdata (bus.data_out)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.num_elem     = count;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_full  = afull_q;
  assign bus.err_overwr   = err_overwr_q;
  assign bus.err_underrun = err_underrun_q;

`ifdef DATAFRAME_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q;
  logic [ADDR_W:0]       hw_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      drop_q <= '0;
      hw_q   <= '0;
    end else begin
      if (overwr_event && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      if (count_next > hw_q)              hw_q   <= count_next;
    end
  end

  assign bus.drop_count = drop_q;
  assign bus.high_water = hw_q;
`else
  assign bus.drop_count = '0;
  assign bus.high_water = '0;
`endif

endmodule
